stage_sequencer: RTL and testbench

Multi-cycle control sequencer for the RISC processor core. It walks each instruction through the fetch, decode, execute, memory and write-back stages, which all run on the single processor `clock`. It issues the per-stage enables for the PC, instruction register, register file and data memory. It stalls on memory wait states and stops the core on HALT.

---
 rtl/stage_sequencer.sv | 176 +++++++++++++++++
 tb/tb_stage_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//   Multi-cycle control sequencer for the RISC core. Walks each instruction
//   through IF/ID/EX/MEM/WB, issues PC/IR/register-file/data-memory enables,
//   stalls on memory wait states and stops the core on HALT.
//
// Ports
//   clock        in   processor clock, rising-edge active
//   reset        in   asynchronous active-low reset (state -> IF, counter -> 0)
//   instr_class  in   [2:0] decoded class of IR (0 ALU,1 LOAD,2 STORE,
//                     3 BRANCH,4 JUMP,5 HALT, 6/7 treated as ALU)
//   branch_taken in   ALU comparison result, used only in EX
//   mem_ready    in   memory handshake, used in IF and MEM
//   stage        out  [4:0] one-hot stage (IF,ID,EX,MEM,WB), zero when halted
//   ir_write     out  load instruction register
//   pc_write     out  load PC
//   pc_src       out  [1:0] PC mux: 0 PC+1, 1 branch target, 2 jump target
//   mem_read     out  memory read strobe
//   mem_write    out  data memory write strobe
//   reg_write    out  register file write enable
//   halted       out  core stopped
//   retired      out  [CNT_W-1:0] completed-instruction count, wraps
// -----------------------------------------------------------------------------
module stage_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       instr_class,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic [4:0]       stage,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;

    localparam logic [2:0] C_ALU    = 3'd0;
    localparam logic [2:0] C_LOAD   = 3'd1;
    localparam logic [2:0] C_STORE  = 3'd2;
    localparam logic [2:0] C_BRANCH = 3'd3;
    localparam logic [2:0] C_JUMP   = 3'd4;
    localparam logic [2:0] C_HALT   = 3'd5;

    localparam logic [1:0] PC_INC    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    logic [2:0]       state_q, state_d;
    logic [2:0]       cls_q, cls_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       cur_cls;
    logic             retire;

    // Reserved encodings fold onto ALU so they follow the ALU path.
    function automatic logic [2:0] norm_class(input logic [2:0] c);
        return (c > C_HALT) ? C_ALU : c;
    endfunction

    // In ID the decoder output is used live and captured; later stages only
    // see the captured copy, so decoder glitches after ID cannot steer us.
    assign cur_cls = (state_q == S_ID) ? norm_class(instr_class) : cls_q;
    assign cls_d   = cur_cls;

    // NOTE: every output and next-state variable gets a default before the
    // case so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        ir_write = 1'b0;
        pc_write = 1'b0;
        pc_src   = PC_INC;
        case (state_q)
            S_IF: begin
                // Fetch strobes are qualified by reset so they stay quiet while
                // reset is held even though mem_ready may be high.
                if (mem_ready && reset) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_ID;
                end
            end
            S_ID: begin
                case (cur_cls)
                    C_JUMP: begin
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                        retire   = 1'b1;
                        state_d  = S_IF;
                    end
                    C_HALT: begin
                        retire  = 1'b1;
                        state_d = S_HALT;
                    end
                    default: state_d = S_EX;
                endcase
            end
            S_EX: begin
                case (cur_cls)
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_BRANCH: begin
                        pc_write = branch_taken;
                        pc_src   = branch_taken ? PC_BRANCH : PC_INC;
                        retire   = 1'b1;
                        state_d  = S_IF;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (cur_cls == C_STORE) begin
                        retire  = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = S_IF;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, retire};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IF;
            cls_q   <= C_ALU;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore outputs decoded from state and the captured class.
    always_comb begin
        stage = 5'b00000;
        case (state_q)
            S_IF:    stage = 5'b00001;
            S_ID:    stage = 5'b00010;
            S_EX:    stage = 5'b00100;
            S_MEM:   stage = 5'b01000;
            S_WB:    stage = 5'b10000;
            default: stage = 5'b00000;
        endcase
    end

    assign mem_read  = (state_q == S_IF) || ((state_q == S_MEM) && (cls_q == C_LOAD));
    assign mem_write = (state_q == S_MEM) && (cls_q == C_STORE);
    assign reg_write = (state_q == S_WB);
    assign halted    = (state_q == S_HALT);
    assign retired   = cnt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
//   Self-checking bench for stage_sequencer. Each instruction scenario pushes
//   its expected per-cycle inputs and outputs onto a scoreboard queue, which is
//   then drained one clock cycle per entry. A second instance with CNT_W = 2
//   shares the inputs and is used for the counter wrap check.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;

    logic       clock        = 1'b0;
    logic       reset        = 1'b1;
    logic [2:0] instr_class  = 3'd0;
    logic       branch_taken = 1'b0;
    logic       mem_ready    = 1'b0;

    logic [4:0]  stage;
    logic        ir_write, pc_write, mem_read, mem_write, reg_write, halted;
    logic [1:0]  pc_src;
    logic [15:0] retired;

    logic [4:0]  stage_w;
    logic        ir_write_w, pc_write_w, mem_read_w, mem_write_w, reg_write_w, halted_w;
    logic [1:0]  pc_src_w;
    logic [1:0]  retired_w;

    stage_sequencer #(.CNT_W(16)) dut (
        .clock(clock), .reset(reset), .instr_class(instr_class),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .stage(stage), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .halted(halted), .retired(retired)
    );

    stage_sequencer #(.CNT_W(2)) dut_w (
        .clock(clock), .reset(reset), .instr_class(instr_class),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .stage(stage_w), .ir_write(ir_write_w), .pc_write(pc_write_w), .pc_src(pc_src_w),
        .mem_read(mem_read_w), .mem_write(mem_write_w), .reg_write(reg_write_w),
        .halted(halted_w), .retired(retired_w)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        rdy;
        logic [2:0]  cls;
        logic        taken;
        logic [4:0]  stg;
        logic        irw;
        logic        pcw;
        logic [1:0]  pcs;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        hl;
        logic [15:0] ret;
    } cyc_t;

    cyc_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_ret  = 16'd0;

    task automatic push(input logic rdy, input logic [2:0] cls, input logic taken,
                        input logic [4:0] stg, input logic irw, input logic pcw,
                        input logic [1:0] pcs, input logic mr, input logic mw,
                        input logic rw, input logic hl);
        cyc_t e;
        e.rdy = rdy; e.cls = cls; e.taken = taken; e.stg = stg;
        e.irw = irw; e.pcw = pcw; e.pcs = pcs; e.mr = mr; e.mw = mw;
        e.rw = rw; e.hl = hl; e.ret = exp_ret;
        sb.push_back(e);
    endtask

    // One cycle parked in IF with memory not ready: nothing moves.
    task automatic push_idle();
        push(1'b0, 3'd0, 1'b1, 5'b00001, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Expected cycle sequence of one instruction, built from the stage paths.
    task automatic push_instr(input logic [2:0] cls, input logic taken,
                              input int if_wait, input int mem_wait);
        logic [2:0] eff;
        logic [2:0] glitch;
        logic       noise;
        logic       ld, st, br;
        eff    = (cls > 3'd5) ? 3'd0 : cls;
        glitch = (eff == 3'd1) ? 3'd3 : 3'd1;
        ld = (eff == 3'd1); st = (eff == 3'd2); br = (eff == 3'd3);
        for (int i = 0; i < if_wait; i++)
            push(1'b0, glitch, 1'b1, 5'b00001, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b1, glitch, 1'b1, 5'b00001, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        noise = 1'($urandom_range(0, 1));
        push(noise, cls, 1'b1, 5'b00010, 1'b0, (eff == 3'd4),
             (eff == 3'd4) ? 2'd2 : 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (eff == 3'd4 || eff == 3'd5) begin
            exp_ret++;
            return;
        end
        noise = 1'($urandom_range(0, 1));
        push(noise, glitch, taken, 5'b00100, 1'b0, br && taken,
             (br && taken) ? 2'd1 : 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (br) begin
            exp_ret++;
            return;
        end
        if (ld || st) begin
            for (int i = 0; i < mem_wait; i++)
                push(1'b0, glitch, 1'b1, 5'b01000, 1'b0, 1'b0, 2'd0, ld, st, 1'b0, 1'b0);
            push(1'b1, glitch, 1'b1, 5'b01000, 1'b0, 1'b0, 2'd0, ld, st, 1'b0, 1'b0);
            if (st) begin
                exp_ret++;
                return;
            end
        end
        noise = 1'($urandom_range(0, 1));
        push(noise, glitch, 1'b1, 5'b10000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_ret++;
    endtask

    task automatic push_halted(input int n);
        for (int i = 0; i < n; i++)
            push(1'(i), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 5'b00000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Apply each entry's inputs at the falling edge, compare just after.
    task automatic drain(input string tag);
        cyc_t        e;
        logic [28:0] act, expv;
        int          n;
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clock);
            mem_ready    = e.rdy;
            instr_class  = e.cls;
            branch_taken = e.taken;
            #1;
            act  = {stage, ir_write, pc_write, pc_src, mem_read, mem_write,
                    reg_write, halted, retired};
            expv = {e.stg, e.irw, e.pcw, e.pcs, e.mr, e.mw, e.rw, e.hl, e.ret};
            checks++;
            if (act !== expv) begin
                failures++;
                $display("FAIL %s cycle %0d {stage,irw,pcw,pcsrc,mr,mw,rw,halt,retired} got %b expected %b",
                         tag, n, act, expv);
            end
            n++;
        end
    endtask

    // Assert reset (asynchronously, wherever we are) and hold it 3 more cycles
    // with mem_ready high; release at a falling edge with mem_ready low.
    task automatic apply_reset(input string tag);
        logic [30:0] act;
        logic [30:0] expv;
        expv = {5'b00001, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 2'd0};
        reset        = 1'b0;
        mem_ready    = 1'b1;
        instr_class  = 3'd5;
        branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            act = {stage, ir_write, pc_write, pc_src, mem_read, mem_write,
                   reg_write, halted, retired, retired_w};
            checks++;
            if (act !== expv) begin
                failures++;
                $display("FAIL %s reset cycle %0d got %b expected %b", tag, i, act, expv);
            end
        end
        @(negedge clock);
        reset     = 1'b1;
        mem_ready = 1'b0;
        exp_ret   = 16'd0;
    endtask

    task automatic test_reset();
        apply_reset("reset");
    endtask

    task automatic test_alu_load();
        push_instr(3'd0, 1'b1, 0, 0);
        push_instr(3'd1, 1'b1, 0, 0);
        push_idle();
        drain("alu_load");
    endtask

    task automatic test_fetch_stall();
        push_instr(3'd0, 1'b0, 3, 0);
        push_instr(3'd6, 1'b1, 0, 0);
        push_instr(3'd7, 1'b0, 1, 0);
        drain("fetch_stall");
    endtask

    task automatic test_branch();
        push_instr(3'd3, 1'b1, 0, 0);
        push_instr(3'd3, 1'b0, 0, 0);
        push_instr(3'd4, 1'b1, 0, 0);
        push_instr(3'd1, 1'b0, 1, 2);
        push_idle();
        drain("branch");
    endtask

    task automatic test_reset_mid_mem();
        push(1'b1, 3'd0, 1'b0, 5'b00001, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        push(1'b1, 3'd1, 1'b0, 5'b00010, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b1, 3'd3, 1'b1, 5'b00100, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        push(1'b0, 3'd3, 1'b1, 5'b01000, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drain("pre_mid_mem");
        apply_reset("mid_mem");
    endtask

    task automatic test_store_halt();
        push_instr(3'd2, 1'b1, 0, 2);
        push_instr(3'd5, 1'b1, 0, 0);
        push_halted(5);
        drain("store_halt");
        apply_reset("from_halt");
    endtask

    task automatic test_wrap();
        push_instr(3'd4, 1'b0, 0, 0);
        push_instr(3'd4, 1'b1, 0, 0);
        push_idle();
        drain("wrap_a");
        checks++;
        if (retired_w !== 2'd2) begin
            failures++;
            $display("FAIL wrap_half retired_w got %0d expected 2", retired_w);
        end
        push_instr(3'd4, 1'b0, 0, 0);
        push_instr(3'd4, 1'b1, 0, 0);
        push_idle();
        drain("wrap_b");
        checks++;
        if (retired_w !== 2'd0) begin
            failures++;
            $display("FAIL wrap_full retired_w got %0d expected 0", retired_w);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_alu_load();
        test_fetch_stall();
        test_branch();
        test_reset_mid_mem();
        test_store_halt();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
